// File: rtl/trsq_pc_seq.sv
// TRSQ8 program-counter sequencer: PC, multi-level return stack, vectored prioritised IRQs.
// Optional nested interrupts are built when TRSQ_IRQ_NEST_EN is defined.
module trsq_pc_seq #(
  parameter int AW         = 13,
  parameter int DEPTH      = 4,
  parameter int NIRQ       = 4,
  parameter int VEC_BASE   = 4,
  parameter int VEC_STRIDE = 2
) (
  input  logic            clk_ip,
  input  logic            reset_n_ip,
  input  logic            halt_ip,
  input  logic            jmp_ip,
  input  logic            call_ip,
  input  logic            ret_ip,
  input  logic            reti_ip,
  input  logic            sk_ip,
  input  logic [AW-1:0]   target_ip,
  input  logic [NIRQ-1:0] irq_ip,
  input  logic [NIRQ-1:0] irq_mask_ip,
  input  logic            clr_err_ip,
  output logic [AW-1:0]   prom_addr,
  output logic            irq_ack_op,
  output logic [2:0]      irq_id_op,
  output logic            in_isr_op,
  output logic            stk_ovf_op,
  output logic            stk_unf_op
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);

  function automatic logic [AW-1:0] vec_addr(input logic [2:0] id);
    return AW'(VEC_BASE) + (AW'(id) * AW'(VEC_STRIDE));
  endfunction

  logic [AW-1:0]   pc_r;
  logic [AW-1:0]   stk_r [DEPTH];
  logic [SPW-1:0]  sp_r;
  logic [NIRQ-1:0] irq_q_r;
  logic [NIRQ-1:0] pend_r;
  logic            in_isr_r;
  logic            ack_r;
  logic [2:0]      id_r;
  logic            ovf_r;
  logic            unf_r;

`ifdef TRSQ_IRQ_NEST_EN
  localparam logic [3:0] LVL_IDLE = 4'(NIRQ);
  logic [3:0] lvl_r;
  logic       stk_isr_r [DEPTH];
  logic [3:0] stk_lvl_r [DEPTH];
`endif

  logic            plain_s;
  logic            gate_s;
  logic            take_s;
  logic            push_s;
  logic            pop_s;
  logic            pop_reti_s;
  logic            full_s;
  logic            empty_s;
  logic [2:0]      win_s;
  logic [NIRQ-1:0] cand_s;
  logic [NIRQ-1:0] ack_mask_s;
  logic [NIRQ-1:0] pend_next_s;
  logic [AW-1:0]   pc_inc_s;
  logic [AW-1:0]   pc_next_s;
  logic [IW-1:0]   top_idx_s;
  logic [IW-1:0]   push_idx_s;

  assign full_s     = (sp_r == SP_FULL);
  assign empty_s    = (sp_r == {SPW{1'b0}});
  assign top_idx_s  = IW'(sp_r - SP_ONE);
  assign push_idx_s = IW'(sp_r);
  assign pc_inc_s   = pc_r + AW'(1);
  assign plain_s    = ~(jmp_ip | call_ip | ret_ip | reti_ip | sk_ip);
  assign cand_s     = pend_r & irq_mask_ip;

  // Lowest-index enabled pending source wins.
  always_comb begin
    win_s = 3'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      win_s = cand_s[i] ? 3'(i) : win_s;
    end
  end

`ifdef TRSQ_IRQ_NEST_EN
  assign gate_s = ({1'b0, win_s} < lvl_r);
`else
  assign gate_s = ~in_isr_r;
`endif
  assign take_s      = (|cand_s) & gate_s & (halt_ip | plain_s);
  assign ack_mask_s  = take_s ? (NIRQ'(1'b1) << win_s) : {NIRQ{1'b0}};
  assign pend_next_s = (pend_r | (irq_ip & ~irq_q_r)) & ~ack_mask_s;
  assign pop_reti_s  = pop_s & reti_ip;

  // Next-PC selection in strobe priority order; a dropped push still redirects the PC.
  always_comb begin
    push_s    = 1'b0;
    pop_s     = 1'b0;
    pc_next_s = pc_inc_s;
    if (take_s) begin
      push_s    = 1'b1;
      pc_next_s = vec_addr(win_s);
    end else if (halt_ip) begin
      pc_next_s = pc_r;
    end else if (jmp_ip) begin
      pc_next_s = target_ip;
    end else if (call_ip) begin
      push_s    = 1'b1;
      pc_next_s = target_ip;
    end else if (ret_ip | reti_ip) begin
      pop_s     = 1'b1;
      pc_next_s = empty_s ? pc_inc_s : stk_r[top_idx_s];
    end else if (sk_ip) begin
      pc_next_s = pc_r + AW'(2);
    end else begin
      pc_next_s = pc_inc_s;
    end
  end

  // Sequencer state: PC, stack pointer, interrupt bookkeeping and sticky flags.
  always_ff @(posedge clk_ip) begin
    if (!reset_n_ip) begin
      pc_r     <= {AW{1'b0}};
      sp_r     <= {SPW{1'b0}};
      irq_q_r  <= {NIRQ{1'b0}};
      pend_r   <= {NIRQ{1'b0}};
      in_isr_r <= 1'b0;
      ack_r    <= 1'b0;
      id_r     <= 3'd0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
`ifdef TRSQ_IRQ_NEST_EN
      lvl_r    <= LVL_IDLE;
`endif
    end else begin
      pc_r    <= pc_next_s;
      irq_q_r <= irq_ip;
      pend_r  <= pend_next_s;
      ack_r   <= take_s;
      if (take_s) begin
        id_r <= win_s;
      end
      if (push_s && !full_s) begin
        sp_r <= sp_r + SP_ONE;
      end else if (pop_s && !empty_s) begin
        sp_r <= sp_r - SP_ONE;
      end
      // A set event in the same cycle as a clear leaves the flag set.
      ovf_r <= (push_s & full_s) | (ovf_r & ~clr_err_ip);
      unf_r <= (pop_s & empty_s) | (unf_r & ~clr_err_ip);
`ifdef TRSQ_IRQ_NEST_EN
      if (take_s) begin
        in_isr_r <= 1'b1;
        lvl_r    <= {1'b0, win_s};
      end else if (pop_reti_s) begin
        in_isr_r <= empty_s ? 1'b0 : stk_isr_r[top_idx_s];
        lvl_r    <= empty_s ? LVL_IDLE : stk_lvl_r[top_idx_s];
      end
`else
      if (take_s) begin
        in_isr_r <= 1'b1;
      end else if (pop_reti_s) begin
        in_isr_r <= 1'b0;
      end
`endif
    end
  end

  // Return-stack storage; contents are intentionally not reset.
  always_ff @(posedge clk_ip) begin
    if (reset_n_ip && push_s && !full_s) begin
      stk_r[push_idx_s] <= pc_inc_s;
`ifdef TRSQ_IRQ_NEST_EN
      stk_isr_r[push_idx_s] <= in_isr_r;
      stk_lvl_r[push_idx_s] <= lvl_r;
`endif
    end
  end

  assign prom_addr  = pc_r;
  assign irq_ack_op = ack_r;
  assign irq_id_op  = id_r;
  assign in_isr_op  = in_isr_r;
  assign stk_ovf_op = ovf_r;
  assign stk_unf_op = unf_r;

endmodule
